// File: rtl/dpd_seq_converter.sv
// dpd_seq_converter
//   Sequential converter between binary, BCD and densely packed decimal (DPD)
//   over DECLETS declets (3*DECLETS decimal digits). All conversions pass
//   through a canonical form of 3*DECLETS BCD digits. Binary to decimal uses a
//   bit-serial double-dabble and decimal to binary uses a reverse dabble, one
//   bit per cycle each. DPD<->BCD is combinational per declet.
//
//   Optional feature: define DPD_SEQ_CONVERTER_ERRCNT_EN to add err_count, a
//   saturating count of completed output handshakes that carried any flag.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready request handshake (in_ready high only when idle)
//   src_fmt, dst_fmt  0 BIN, 1 BCD, 2 DPD, 3 illegal; sampled on accept
//   in_data           operand (BIN low BIN_W bits, DPD low 10*DECLETS bits)
//   out_valid/out_ready result handshake; result held until consumed
//   out_data          result, zero-extended
//   out_flags         [0] overflow [1] bad BCD [2] non-canonical DPD [3] illegal fmt
//   busy              binary/decimal iteration in progress
//   err_count         (optional) saturating flagged-result counter
module dpd_seq_converter #(
    parameter int DECLETS = 2,
    parameter int BIN_W   = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            src_fmt,
    input  logic [1:0]            dst_fmt,
    input  logic [12*DECLETS-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [12*DECLETS-1:0] out_data,
    output logic [3:0]            out_flags,
`ifdef DPD_SEQ_CONVERTER_ERRCNT_EN
    output logic [7:0]            err_count,
`endif
    output logic                  busy
);

    localparam int DW = 12 * DECLETS;
    localparam int ND = 3 * DECLETS;
    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [1:0] FMT_BIN = 2'd0;
    localparam logic [1:0] FMT_BCD = 2'd1;
    localparam logic [1:0] FMT_DPD = 2'd2;
    localparam logic [1:0] FMT_ILL = 2'd3;

    typedef enum logic [1:0] {IDLE, TO_DEC, TO_BIN, HOLD} state_t;

    // Declet bits are p q r s t u v w x y = c[9:0].
    function automatic logic [11:0] dpd_unpack(input logic [9:0] c);
        logic [3:0] d2, d1, d0;
        d2 = {1'b0, c[9:7]};
        d1 = {1'b0, c[6:4]};
        d0 = {1'b0, c[2:0]};
        if (c[3]) begin
            case (c[2:1])
                2'b00: d0 = {3'b100, c[0]};
                2'b01: begin d1 = {3'b100, c[4]}; d0 = {1'b0, c[6:5], c[0]}; end
                2'b10: begin d2 = {3'b100, c[7]}; d0 = {1'b0, c[9:8], c[0]}; end
                default: begin
                    case (c[6:5])
                        2'b00: begin d2 = {3'b100, c[7]}; d1 = {3'b100, c[4]}; d0 = {1'b0, c[9:8], c[0]}; end
                        2'b01: begin d2 = {3'b100, c[7]}; d1 = {1'b0, c[9:8], c[4]}; d0 = {3'b100, c[0]}; end
                        2'b10: begin d2 = {1'b0, c[9:7]}; d1 = {3'b100, c[4]}; d0 = {3'b100, c[0]}; end
                        default: begin d2 = {3'b100, c[7]}; d1 = {3'b100, c[4]}; d0 = {3'b100, c[0]}; end
                    endcase
                end
            endcase
        end
        return {d2, d1, d0};
    endfunction

    // The 24 redundant codes: all three digits large with p/q not both zero.
    function automatic logic dpd_noncanon(input logic [9:0] c);
        return c[3] & c[2] & c[1] & c[6] & c[5] & (c[9] | c[8]);
    endfunction

    // Canonical packing keyed on which digits are 8 or 9.
    function automatic logic [9:0] dpd_pack(input logic [11:0] d);
        logic [9:0] r;
        case ({d[11], d[7], d[3]})
            3'b000:  r = {d[10:8], d[6:4], 1'b0, d[2:0]};
            3'b001:  r = {d[10:8], d[6:4], 3'b100, d[0]};
            3'b010:  r = {d[10:8], d[2:1], d[4], 3'b101, d[0]};
            3'b100:  r = {d[2:1], d[8], d[6:4], 3'b110, d[0]};
            3'b110:  r = {d[2:1], d[8], 2'b00, d[4], 3'b111, d[0]};
            3'b101:  r = {d[6:5], d[8], 2'b01, d[4], 3'b111, d[0]};
            3'b011:  r = {d[10:8], 2'b10, d[4], 3'b111, d[0]};
            default: r = {2'b00, d[8], 2'b11, d[4], 3'b111, d[0]};
        endcase
        return r;
    endfunction

    // Result MSB is the carry lost from the top digit; the rest is the next BCD value.
    function automatic logic [DW:0] dabble_step(input logic [DW-1:0] bcd, input logic msb);
        logic [DW-1:0] adj;
        for (int i = 0; i < ND; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return {adj, msb};
    endfunction

    function automatic logic [DW-1:0] rdabble_step(input logic [DW-1:0] bcd);
        logic [DW-1:0] sh;
        sh = bcd >> 1;
        for (int i = 0; i < ND; i++) begin
            if (sh[4*i +: 4] >= 4'd8) sh[4*i +: 4] = sh[4*i +: 4] - 4'd3;
        end
        return sh;
    endfunction

    function automatic logic [DW-1:0] format_dec(input logic [DW-1:0] bcd, input logic [1:0] fmt);
        logic [DW-1:0] r;
        r = '0;
        if (fmt == FMT_DPD) begin
            for (int k = 0; k < DECLETS; k++) r[10*k +: 10] = dpd_pack(bcd[12*k +: 12]);
        end else begin
            r = bcd;
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [BIN_W-1:0] bin_q;
    logic [DW-1:0]   bcd_q;
    logic [3:0]      flags_q;
    logic [1:0]      dst_q;

    logic [DW-1:0]   bcd_clean, dpd_bcd, in_canon;
    logic            bad_bcd, non_canon, illegal;
    logic [3:0]      in_flg;
    logic            last_step;
    logic [DW:0]     dab;
    logic [DW-1:0]   rd;
    logic [BIN_W-1:0] bin_nx;
    logic [BIN_W:0]  bin_cat;

    // Decode the operand into canonical BCD on the accept cycle.
    always_comb begin
        bcd_clean = in_data;
        bad_bcd   = 1'b0;
        for (int k = 0; k < ND; k++) begin
            if (in_data[4*k +: 4] > 4'd9) begin
                bcd_clean[4*k +: 4] = 4'd0;
                bad_bcd = 1'b1;
            end
        end
        dpd_bcd   = '0;
        non_canon = 1'b0;
        for (int k = 0; k < DECLETS; k++) begin
            dpd_bcd[12*k +: 12] = dpd_unpack(in_data[10*k +: 10]);
            non_canon = non_canon | dpd_noncanon(in_data[10*k +: 10]);
        end
        illegal  = (src_fmt == FMT_ILL) || (dst_fmt == FMT_ILL);
        in_canon = (src_fmt == FMT_DPD) ? dpd_bcd : bcd_clean;
        in_flg   = illegal ? 4'b1000
                           : {1'b0, (src_fmt == FMT_DPD) & non_canon, (src_fmt == FMT_BCD) & bad_bcd, 1'b0};
    end

    assign last_step = (cnt_q == '0);
    assign dab       = dabble_step(bcd_q, bin_q[BIN_W-1]);
    assign rd        = rdabble_step(bcd_q);
    assign bin_cat   = {bcd_q[0], bin_q};
    assign bin_nx    = bin_cat[BIN_W:1];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        busy      = (state_q == TO_DEC) || (state_q == TO_BIN);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (illegal)                  state_d = HOLD;
                    else if (src_fmt == FMT_BIN)  state_d = TO_DEC;
                    else if (dst_fmt == FMT_BIN)  state_d = TO_BIN;
                    else                          state_d = HOLD;
                end
            end
            TO_DEC:  if (last_step) state_d = (dst_q == FMT_BIN) ? TO_BIN : HOLD;
            TO_BIN:  if (last_step) state_d = HOLD;
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            out_data  <= '0;
            out_flags <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dst_q   <= dst_fmt;
                        flags_q <= in_flg;
                        cnt_q   <= CW'(BIN_W - 1);
                        bin_q   <= (src_fmt == FMT_BIN) ? in_data[BIN_W-1:0] : '0;
                        bcd_q   <= (src_fmt == FMT_BIN) ? '0 : in_canon;
                        // Decimal-to-decimal and illegal requests finish here.
                        if (illegal || (src_fmt != FMT_BIN && dst_fmt != FMT_BIN)) begin
                            out_data  <= illegal ? '0 : format_dec(in_canon, dst_fmt);
                            out_flags <= in_flg;
                        end
                    end
                end
                TO_DEC: begin
                    bin_q      <= bin_q << 1;
                    bcd_q      <= dab[DW-1:0];
                    flags_q[0] <= flags_q[0] | dab[DW];
                    cnt_q      <= last_step ? CW'(BIN_W - 1) : cnt_q - 1'b1;
                    if (last_step && dst_q != FMT_BIN) begin
                        out_data  <= format_dec(dab[DW-1:0], dst_q);
                        out_flags <= flags_q | {3'b000, dab[DW]};
                    end
                end
                TO_BIN: begin
                    bin_q <= bin_nx;
                    bcd_q <= rd;
                    cnt_q <= cnt_q - 1'b1;
                    // Residual decimal value means the number did not fit in BIN_W bits.
                    if (last_step) begin
                        out_data  <= DW'(bin_nx);
                        out_flags <= flags_q | {3'b000, |rd};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DPD_SEQ_CONVERTER_ERRCNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)                                      err_cnt_q <= '0;
        else if (out_valid && out_ready && |out_flags)   err_cnt_q <= sat_inc(err_cnt_q);
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_dpd_seq_converter.sv
// Testbench for dpd_seq_converter (DECLETS=2, BIN_W=20): directed vectors
// followed by randomized transactions checked against a value-level model.
module tb_dpd_seq_converter;

    localparam int DECLETS = 2;
    localparam int BIN_W   = 20;
    localparam int DW      = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    src_fmt;
    logic [1:0]    dst_fmt;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [3:0]    out_flags;
    logic          busy;
`ifdef DPD_SEQ_CONVERTER_ERRCNT_EN
    logic [7:0]    err_count;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int exp_err = 0;
    int enc_tab [1000];

    dpd_seq_converter #(.DECLETS(DECLETS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_fmt   (src_fmt),
        .dst_fmt   (dst_fmt),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
`ifdef DPD_SEQ_CONVERTER_ERRCNT_EN
        .err_count (err_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // IEEE 754-2008 declet decode, as a three-digit value.
    function automatic int dpd_val(input logic [9:0] c);
        int pq, r, st, u, y, d2, d1, d0;
        pq = int'(c[9:8]); r = int'(c[7]); st = int'(c[6:5]); u = int'(c[4]); y = int'(c[0]);
        d2 = 2*pq + r; d1 = 2*st + u; d0 = int'(c[2:0]);
        if (c[3]) begin
            case (c[2:1])
                2'b00: d0 = 8 + y;
                2'b01: begin d1 = 8 + u; d0 = 2*st + y; end
                2'b10: begin d2 = 8 + r; d0 = 2*pq + y; end
                default: begin
                    case (st)
                        0:       begin d2 = 8 + r;      d1 = 8 + u;      d0 = 2*pq + y; end
                        1:       begin d2 = 8 + r;      d1 = 2*pq + u;   d0 = 8 + y;    end
                        2:       begin d2 = 2*pq + r;   d1 = 8 + u;      d0 = 8 + y;    end
                        default: begin d2 = 8 + r;      d1 = 8 + u;      d0 = 8 + y;    end
                    endcase
                end
            endcase
        end
        return 100*d2 + 10*d1 + d0;
    endfunction

    function automatic bit dpd_nc(input logic [9:0] c);
        return (c[3] == 1'b1) && (c[2:1] == 2'b11) && (c[6:5] == 2'b11) && (c[9:8] != 2'b00);
    endfunction

    task automatic model(input logic [1:0] s, input logic [1:0] d, input logic [DW-1:0] data,
                         output logic [DW-1:0] od, output logic [3:0] of, output int lat);
        int v, dg, p;
        od = '0; of = '0; v = 0;
        lat = 1 + ((s == 2'd0) ? BIN_W : 0) + ((d == 2'd0) ? BIN_W : 0);
        if (s == 2'd3 || d == 2'd3) begin
            of = 4'b1000; lat = 1;
        end else begin
            case (s)
                2'd0: begin
                    v = int'(data[19:0]);
                    if (v >= 1000000) of[0] = 1'b1;
                    v = v % 1000000;
                end
                2'd1: begin
                    for (int i = 5; i >= 0; i--) begin
                        dg = int'(data[4*i +: 4]);
                        if (dg > 9) begin of[1] = 1'b1; dg = 0; end
                        v = v*10 + dg;
                    end
                end
                default: begin
                    v = dpd_val(data[19:10]) * 1000 + dpd_val(data[9:0]);
                    if (dpd_nc(data[19:10]) || dpd_nc(data[9:0])) of[2] = 1'b1;
                end
            endcase
            case (d)
                2'd0: begin
                    if (v >= (1 << BIN_W)) of[0] = 1'b1;
                    od = DW'(v % (1 << BIN_W));
                end
                2'd1: begin
                    p = 1;
                    for (int i = 0; i < 6; i++) begin
                        od[4*i +: 4] = 4'((v / p) % 10);
                        p = p * 10;
                    end
                end
                default: begin
                    od[19:10] = 10'(enc_tab[v / 1000]);
                    od[9:0]   = 10'(enc_tab[v % 1000]);
                end
            endcase
        end
    endtask

    // One transaction from an idle cycle through to the output handshake.
    task automatic do_txn(input logic [1:0] s, input logic [1:0] d, input logic [DW-1:0] data,
                          input logic [DW-1:0] od, input logic [3:0] of, input int lat, input int stall);
        int cyc;
        in_valid = 1'b1; src_fmt = s; dst_fmt = d; in_data = data;
        check("in_ready_before_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'(($urandom % 2)); src_fmt = 2'($urandom); dst_fmt = 2'($urandom); in_data = 24'($urandom);
        cyc = 1;
        if (lat > 1) check("busy_during_conv", busy, 1);
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, lat);
        check("out_data", out_data, od);
        check("out_flags", out_flags, of);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_data", out_data, od);
            check("hold_flags", out_flags, of);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (of != 4'd0 && exp_err < 255) exp_err++;
        check("valid_drop", out_valid, 0);
        check("in_ready_rise", in_ready, 1);
`ifdef DPD_SEQ_CONVERTER_ERRCNT_EN
        check("err_count", err_count, exp_err);
`endif
    endtask

    task automatic rand_txn();
        logic [1:0] s, d;
        logic [DW-1:0] data, od;
        logic [3:0] of;
        int lat;
        s = 2'($urandom_range(0, 3));
        d = 2'($urandom_range(0, 3));
        data = 24'($urandom);
        if (s == 2'd1) begin
            for (int i = 0; i < 6; i++)
                data[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        end
        model(s, d, data, od, of, lat);
        do_txn(s, d, data, od, of, lat, $urandom_range(0, 3));
    endtask

    initial begin
        int vcount;
        for (int c = 0; c < 1000; c++) enc_tab[c] = 0;
        for (int c = 0; c < 1024; c++)
            if (!dpd_nc(10'(c))) enc_tab[dpd_val(10'(c))] = c;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src_fmt = 2'd0; dst_fmt = 2'd0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_err = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_busy", busy, 0);
`ifdef DPD_SEQ_CONVERTER_ERRCNT_EN
        check("rst_err_count", err_count, 0);
`endif

        do_txn(2'd0, 2'd2, 24'h0F423F, 24'h03FCFF, 4'b0000, 21, 0);
        do_txn(2'd0, 2'd1, 24'h0F4240, 24'h000000, 4'b0001, 21, 0);
        do_txn(2'd1, 2'd0, 24'h123456, 24'h01E240, 4'b0000, 21, 0);
        do_txn(2'd1, 2'd0, 24'h12A456, 24'h01D688, 4'b0010, 21, 1);
        do_txn(2'd2, 2'd1, 24'h03FCFF, 24'h999999, 4'b0000, 1, 0);
        do_txn(2'd2, 2'd1, 24'h0003FF, 24'h000999, 4'b0100, 1, 0);
        do_txn(2'd1, 2'd2, 24'h123456, 24'h028E56, 4'b0000, 1, 5);
        do_txn(2'd3, 2'd1, 24'h123456, 24'h000000, 4'b1000, 1, 0);
        do_txn(2'd0, 2'd3, 24'h000001, 24'h000000, 4'b1000, 1, 2);
        do_txn(2'd0, 2'd0, 24'h0F4240, 24'h000000, 4'b0001, 41, 0);
        do_txn(2'd0, 2'd0, 24'h003039, 24'h003039, 4'b0000, 41, 0);
        do_txn(2'd2, 2'd2, 24'h0003FF, 24'h0000FF, 4'b0100, 1, 0);
        do_txn(2'd1, 2'd1, 24'h9AB0F1, 24'h900001, 4'b0010, 1, 0);

        // Reset at cycle 10 of a BIN->BIN run.
        in_valid = 1'b1; src_fmt = 2'd0; dst_fmt = 2'd0; in_data = 24'h0ABCDE;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_err = 0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_out_data", out_data, 0);
        vcount = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (out_valid) vcount++;
        end
        check("abort_no_output", vcount, 0);
        do_txn(2'd0, 2'd0, 24'h0F423F, 24'h0F423F, 4'b0000, 41, 0);

        for (int n = 0; n < 80; n++) rand_txn();

`ifdef DPD_SEQ_CONVERTER_ERRCNT_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_err = 0;
        check("errcnt_after_reset", err_count, 0);
        do_txn(2'd3, 2'd0, 24'h0, 24'h0, 4'b1000, 1, 0);
        do_txn(2'd1, 2'd1, 24'h00000A, 24'h000000, 4'b0010, 1, 0);
        do_txn(2'd2, 2'd1, 24'h0003FF, 24'h000999, 4'b0100, 1, 0);
        do_txn(2'd1, 2'd1, 24'h000042, 24'h000042, 4'b0000, 1, 0);
        check("errcnt_three", err_count, 3);
        for (int n = 0; n < 300; n++) do_txn(2'd3, 2'd3, 24'h0, 24'h0, 4'b1000, 1, 0);
        check("errcnt_saturate", err_count, 255);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
